// File: rtl/rggen_address_decoder_array.sv
// Registered multi-window address decoder with valid/ready host handshake,
// one-hot window select, ack wait with optional timeout and error response.
module rggen_address_decoder_array #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int WINDOWS = 4,
  parameter logic [WINDOWS-1:0][ADDRESS_WIDTH-1:0] START_ADDRESS = '0,
  parameter logic [WINDOWS-1:0][ADDRESS_WIDTH-1:0] END_ADDRESS = '0,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_request_valid,
  output logic                     o_request_ready,
  input  logic [ADDRESS_WIDTH-1:0] i_address,
  input  logic                     i_write,
  input  logic [DATA_WIDTH-1:0]    i_write_data,
  output logic [WINDOWS-1:0]       o_select,
  output logic                     o_write,
  output logic [DATA_WIDTH-1:0]    o_write_data,
  input  logic                     i_ack,
  input  logic [DATA_WIDTH-1:0]    i_read_data,
  output logic                     o_response_valid,
  input  logic                     i_response_ready,
  output logic                     o_response_error,
  output logic [DATA_WIDTH-1:0]    o_read_data
);

  localparam int LSB = $clog2(DATA_WIDTH / 8);
  localparam int CW =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST =
    CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESPOND
  } state_e;

  state_e                 state_q, state_d;
  logic [WINDOWS-1:0]     select_q, select_d;
  logic                   write_q, write_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic                   rvalid_q, rvalid_d;
  logic                   err_q, err_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [WINDOWS-1:0]     hit;

  if (LSB > 0) begin : g_unused
    logic unused_addr_bits;
    assign unused_addr_bits = ^i_address[LSB-1:0];
  end

  // Lowest-index matching window wins when windows overlap.
  always_comb begin
    hit = '0;
    for (int i = 0; i < WINDOWS; i++) begin
      if (hit == '0 &&
          i_address[ADDRESS_WIDTH-1:LSB] >=
            START_ADDRESS[i][ADDRESS_WIDTH-1:LSB] &&
          i_address[ADDRESS_WIDTH-1:LSB] <=
            END_ADDRESS[i][ADDRESS_WIDTH-1:LSB]) begin
        hit[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    select_d = select_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    rvalid_d = rvalid_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (i_request_valid) begin
          write_d = i_write;
          wdata_d = i_write_data;
          cnt_d   = '0;
          if (hit != '0) begin
            select_d = hit;
            state_d  = ACCESS;
          end else begin
            rvalid_d = 1'b1;
            err_d    = 1'b1;
            rdata_d  = '0;
            state_d  = RESPOND;
          end
        end
      end
      ACCESS: begin
        if (i_ack) begin
          select_d = '0;
          rvalid_d = 1'b1;
          err_d    = 1'b0;
          rdata_d  = write_q ? '0 : i_read_data;
          state_d  = RESPOND;
        end else if (TIMEOUT_CYCLES > 0 && cnt_q == LAST) begin
          select_d = '0;
          rvalid_d = 1'b1;
          err_d    = 1'b1;
          rdata_d  = '0;
          state_d  = RESPOND;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESPOND: begin
        if (i_response_ready) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      select_q <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      select_q <= select_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_request_ready  = (state_q == IDLE);
  assign o_select         = select_q;
  assign o_write          = write_q;
  assign o_write_data     = wdata_q;
  assign o_response_valid = rvalid_q;
  assign o_response_error = err_q;
  assign o_read_data      = rdata_q;

endmodule
